// File: rtl/serial_word_loader_pkg.sv
// Shared types and helpers for the serial word loader.
// The parity option is selected by the SERIAL_WORD_LOADER_PARITY_EN macro.
// That macro is read in the top module.
package serial_loader_pkg;

  // FSM state encoding. The fourth code is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Number of serial bits in one frame: the data bits, plus one parity bit
  // when parity is enabled.
  function automatic int frame_len(input int width, input bit parity_en);
    return parity_en ? width + 1 : width;
  endfunction

endpackage

// File: rtl/serial_word_loader_if.sv
// Handshake and serial-stream bundle for serial_word_loader.
// The master modport is the producer of the stream and the consumer of the
// word. The slave modport is the loader itself.
interface serial_word_loader_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             bit_valid;
  logic             sdata;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             busy;
  logic             out_perr;

  modport master (
    output start, bit_valid, sdata, out_ready,
    input  out_valid, out_data, busy, out_perr
  );

  modport slave (
    input  start, bit_valid, sdata, out_ready,
    output out_valid, out_data, busy, out_perr
  );
endinterface

// File: rtl/serial_word_loader_shift_accum.sv
// shift_accum: a WIDTH-bit shift register with a synchronous clear and a
// shift enable. MSB_FIRST selects which end new bits enter from.
// o_next is the value the register takes at the next edge when no clear is
// applied. The top latches the completed word from o_next on the same edge
// that the last bit arrives.
module shift_accum #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_shift_en,
  input  logic             i_din,
  output logic [WIDTH-1:0] o_next
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_shifted;

  // Next value of the register: shift the new bit in, or hold the current value.
  always_comb begin
    // NOTE: each always_comb output is assigned a default first, so that no path leaves it unassigned and infers a latch.
    w_shifted = r_q;
    if (MSB_FIRST) w_shifted = {r_q[WIDTH-2:0], i_din};
    else           w_shifted = {i_din, r_q[WIDTH-1:1]};
    o_next = i_shift_en ? w_shifted : r_q;
  end

  // Register update. Clear has priority over shift.
  always_ff @(posedge clk) begin
    // NOTE: reset here is synchronous (sampled on clk), and all state uses non-blocking <= so every flop sees pre-edge values.
    if (!rst_n)       r_q <= '0;
    else if (i_clear) r_q <= '0;
    else              r_q <= o_next;
  end

endmodule

// File: rtl/serial_word_loader.sv
// serial_word_loader: assembles a serial bit stream into a WIDTH-bit word.
// The word is presented with a valid/ready handshake.
// Define SERIAL_WORD_LOADER_PARITY_EN to append an even parity bit to each
// frame and to report out_perr.
module serial_word_loader
  import serial_loader_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                clk,
  input logic                rst_n,
  serial_word_loader_if.slave bus
);

`ifdef SERIAL_WORD_LOADER_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  localparam int FRAME_LEN = frame_len(WIDTH, PARITY_EN);
  localparam int CNT_W     = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_busy;

  logic             w_take;
  logic             w_last;
  logic             w_shift_en;
  logic             w_clear;
  logic [WIDTH-1:0] w_word;

  // A frame bit is taken only in SHIFT and only when no restart is requested.
  // Only data bits enter the shift register; the parity bit does not.
  always_comb begin
    w_take     = (r_state == ST_SHIFT) && !bus.start && bus.bit_valid;
    w_last     = w_take && (r_cnt == LAST_CNT);
    w_shift_en = w_take && (r_cnt <= DATA_LAST);
    w_clear    = bus.start && ((r_state != ST_HOLD) || bus.out_ready);
  end

  shift_accum #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_accum (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_clear),
    .i_shift_en (w_shift_en),
    .i_din      (bus.sdata),
    .o_next     (w_word)
  );

  // Main FSM, bit counter and output word/handshake registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state <= ST_SHIFT;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (bus.start) begin
            r_cnt <= '0;
          end else if (bus.bit_valid) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_state     <= ST_HOLD;
              r_busy      <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_data  <= w_word;
            end
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            if (bus.start) begin
              r_state <= ST_SHIFT;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef SERIAL_WORD_LOADER_PARITY_EN
  logic r_perr;

  // Parity check on the final (parity) bit. The result is loaded together
  // with the word.
  always_ff @(posedge clk) begin
    if (!rst_n)      r_perr <= 1'b0;
    else if (w_last) r_perr <= (^w_word) ^ bus.sdata;
  end

  assign bus.out_perr = r_perr;
`else
  assign bus.out_perr = 1'b0;
`endif

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_serial_word_loader.sv
// Directed bench for serial_word_loader.
// Two instances, MSB-first and LSB-first, receive the same stimulus.
// Each instance is checked against its own hand-computed word.
module tb_serial_word_loader;

  localparam int W = 8;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FL = PAR ? W + 1 : W;

  logic clk = 1'b0;
  logic rst_n, start, bit_valid, sdata, out_ready;

  always #5 clk = ~clk;

  serial_word_loader_if #(.WIDTH(W)) if_m ();
  serial_word_loader_if #(.WIDTH(W)) if_l ();

  assign if_m.start = start;  assign if_m.bit_valid = bit_valid;
  assign if_m.sdata = sdata;  assign if_m.out_ready = out_ready;
  assign if_l.start = start;  assign if_l.bit_valid = bit_valid;
  assign if_l.sdata = sdata;  assign if_l.out_ready = out_ready;

  serial_word_loader #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk (clk), .rst_n (rst_n), .bus (if_m.slave)
  );
  serial_word_loader #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk (clk), .rst_n (rst_n), .bus (if_l.slave)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] word;   // sent MSB of this value first
    int         gap;    // idle cycles after each bit
    logic [7:0] exp_m;  // expected word, MSB_FIRST=1
    logic [7:0] exp_l;  // expected word, MSB_FIRST=0
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; bit_valid = 1'b0; sdata = 1'b0; out_ready = 1'b0;
  endtask

  task automatic check_out(input string name, input logic v, input logic [7:0] dm,
                           input logic [7:0] dl, input logic b, input logic pe);
    check({name, " valid_m"}, if_m.out_valid, v);
    check({name, " valid_l"}, if_l.out_valid, v);
    check({name, " data_m"},  if_m.out_data,  dm);
    check({name, " data_l"},  if_l.out_data,  dl);
    check({name, " busy_m"},  if_m.busy,      b);
    check({name, " busy_l"},  if_l.busy,      b);
    check({name, " perr_m"},  if_m.out_perr,  pe);
    check({name, " perr_l"},  if_l.out_perr,  pe);
  endtask

  task automatic check_valid(input string name, input logic v, input logic b);
    check({name, " valid_m"}, if_m.out_valid, v);
    check({name, " valid_l"}, if_l.out_valid, v);
    check({name, " busy_m"},  if_m.busy,      b);
    check({name, " busy_l"},  if_l.busy,      b);
  endtask

  // Send one full frame: the data bits (word[7] first), then the parity bit
  // if parity is enabled. flip_par inverts the parity bit. Just before the
  // last bit, the word must not be valid yet.
  task automatic send_bits(input string name, input logic [7:0] word, input int gap, input bit flip_par);
    logic b;
    for (int k = 0; k < FL; k++) begin
      b = (k < W) ? word[W-1-k] : ((^word) ^ flip_par);
      if (k == FL - 1) check_valid({name, " pre-last"}, 1'b0, 1'b1);
      bit_valid = 1'b1; sdata = b;
      tick();
      bit_valid = 1'b0; sdata = 1'b0;
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic accept(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_valid({name, " accepted"}, 1'b0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'hA5, 0, 8'hA5, 8'hA5};
    vecs[1] = '{8'hA5, 3, 8'hA5, 8'hA5};
    vecs[2] = '{8'hC0, 3, 8'hC0, 8'h03};
    vecs[3] = '{8'h3C, 1, 8'h3C, 8'h3C};
    vecs[4] = '{8'h01, 0, 8'h01, 8'h80};
    vecs[5] = '{8'hF0, 2, 8'hF0, 8'h0F};
    vecs[6] = '{8'hFF, 0, 8'hFF, 8'hFF};

    idle_inputs();
    rst_n = 1'b0;
    tick(); tick();
    check_out("reset", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    // In IDLE, bit_valid is ignored.
    bit_valid = 1'b1; sdata = 1'b1;
    tick(); tick();
    bit_valid = 1'b0; sdata = 1'b0;
    check_out("idle ignore", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

    // Table-driven frames with different gaps and both bit orders.
    foreach (vecs[i]) begin
      pulse_start();
      check_valid($sformatf("vec%0d start", i), 1'b0, 1'b1);
      send_bits($sformatf("vec%0d", i), vecs[i].word, vecs[i].gap, 1'b0);
      check_out($sformatf("vec%0d hold", i), 1'b1, vecs[i].exp_m, vecs[i].exp_l, 1'b0, 1'b0);
      accept($sformatf("vec%0d", i));
    end

    // Backpressure: the word holds while start and bit_valid pulses arrive.
    pulse_start();
    send_bits("bp", 8'h96, 0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      start = k[0]; bit_valid = 1'b1; sdata = k[1];
      tick();
      check_out($sformatf("bp hold%0d", k), 1'b1, 8'h96, 8'h69, 1'b0, 1'b0);
    end
    idle_inputs();
    accept("bp");

    // Back-to-back: handshake and start in the same HOLD cycle.
    pulse_start();
    send_bits("b2b first", 8'h12, 0, 1'b0);
    check_out("b2b first", 1'b1, 8'h12, 8'h48, 1'b0, 1'b0);
    out_ready = 1'b1; start = 1'b1;
    tick();
    out_ready = 1'b0; start = 1'b0;
    check_valid("b2b restart", 1'b0, 1'b1);
    send_bits("b2b second", 8'h3C, 0, 1'b0);
    check_out("b2b second", 1'b1, 8'h3C, 8'h3C, 1'b0, 1'b0);
    accept("b2b");
    tick(); tick(); tick();
    check_valid("b2b no dup", 1'b0, 1'b0);

    // Abort: a restart in mid-frame discards the partial word and the same-cycle bit.
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      bit_valid = 1'b1; sdata = 1'b1;
      tick();
    end
    start = 1'b1; bit_valid = 1'b1; sdata = 1'b1;
    tick();
    idle_inputs();
    check_valid("abort restart", 1'b0, 1'b1);
    send_bits("abort", 8'hF0, 0, 1'b0);
    check_out("abort", 1'b1, 8'hF0, 8'h0F, 1'b0, 1'b0);
    accept("abort");

    // Reset in SHIFT.
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      bit_valid = 1'b1; sdata = 1'b1;
      tick();
    end
    idle_inputs();
    rst_n = 1'b0;
    tick();
    check_out("rst shift", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    bit_valid = 1'b1; sdata = 1'b1;
    tick(); tick(); tick();
    idle_inputs();
    check_out("rst shift idle", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

    // Reset in HOLD, then recovery with a clean frame.
    pulse_start();
    send_bits("rst hold", 8'h77, 0, 1'b0);
    check_out("rst hold pre", 1'b1, 8'h77, 8'hEE, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    check_out("rst hold", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    pulse_start();
    send_bits("recover", 8'hC0, 1, 1'b0);
    check_out("recover", 1'b1, 8'hC0, 8'h03, 1'b0, 1'b0);
    accept("recover");

`ifdef SERIAL_WORD_LOADER_PARITY_EN
    // Correct and incorrect parity bits; the word is delivered in both cases.
    pulse_start();
    send_bits("par ok", 8'hA5, 0, 1'b0);
    check_out("par ok", 1'b1, 8'hA5, 8'hA5, 1'b0, 1'b0);
    accept("par ok");
    pulse_start();
    send_bits("par err", 8'hA5, 0, 1'b1);
    check_out("par err", 1'b1, 8'hA5, 8'hA5, 1'b0, 1'b1);
    accept("par err");
`else
    // A ninth bit lands in HOLD: it is ignored and starts no frame.
    pulse_start();
    send_bits("nine", 8'hA5, 0, 1'b0);
    bit_valid = 1'b1; sdata = 1'b1;
    tick();
    idle_inputs();
    check_out("nine hold", 1'b1, 8'hA5, 8'hA5, 1'b0, 1'b0);
    accept("nine");
    tick();
    check_out("nine idle", 1'b0, 8'hA5, 8'hA5, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_word_loader.md
Name: serial_word_loader

Overview:
Upstream stage of the enabled parallel register. It assembles a serial bit stream into a WIDTH-bit word and presents it with a valid/ready handshake. Downstream, out_valid && out_ready drives the register's load enable and out_data drives its d input. The block uses a 3-state FSM, a shift register and a bit counter.

Parameters:
WIDTH, 8, data word width in bits (>= 2)
MSB_FIRST, 1, 1: first received bit lands in out_data[WIDTH-1]; 0: first bit lands in out_data[0]

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
start  input  1  pulse; begins a new frame
bit_valid  input  1  sdata is a valid frame bit this cycle
sdata  input  1  serial data bit
out_valid  output  1  out_data holds a complete word
out_ready  input  1  consumer accepts word when high with out_valid
out_data  output  WIDTH  assembled word
busy  output  1  high in SHIFT state
out_perr  output  1  parity error flag for current word (see Optional Feature)

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, out_valid=0, out_data=0, busy=0, out_perr=0, counter=0. Reset overrides all other inputs and aborts any frame, including one in HOLD.
- Counter width: $clog2(WIDTH+2). Counter counts received frame bits.
- IDLE:
  - bit_valid is ignored.
  - start=1 -> SHIFT; counter cleared, shift register cleared.
- SHIFT (busy=1):
  - Each cycle with bit_valid=1: shift sdata in per MSB_FIRST and increment counter.
  - Cycles with bit_valid=0 hold state; gaps of any length are legal.
- SHIFT to HOLD:
  - When the last frame bit (counter == FRAME_LEN-1) is taken with bit_valid=1, go to HOLD.
  - On that same edge, out_data is loaded with the completed word and out_valid becomes 1.
  - Latency: out_valid is high in the cycle after the last bit.
  - FRAME_LEN = WIDTH, or WIDTH+1 with parity.
- start in SHIFT restarts the frame:
  - Counter is cleared and the partial word is discarded.
  - Any bit_valid in that same cycle is discarded.
- HOLD (out_valid=1):
  - out_data and out_perr stay stable until the handshake completes.
  - bit_valid is ignored.
- HOLD exits:
  - out_ready=1 -> IDLE; out_valid=0 next cycle.
  - out_ready=1 and start=1 in the same cycle -> SHIFT directly (back-to-back frame); out_valid=0 next cycle.
  - start without out_ready is ignored (word is never overwritten).
- out_data is updated only on the SHIFT->HOLD transition and retains its value in IDLE/SHIFT.
- Unused state encoding recovers to IDLE.

Optional Feature:
Macro SERIAL_WORD_LOADER_PARITY_EN.
- Defined:
  - FRAME_LEN = WIDTH+1; the final bit is an even parity bit over the data bits.
  - out_perr = 1 when XOR(data bits, parity bit) != 0. It is loaded with out_data and cleared on reset.
  - The word is still delivered when out_perr=1.
- Undefined:
  - FRAME_LEN = WIDTH; out_perr is tied to 0.
  - No parity logic is synthesised.

Decomposition:
- Shared package serial_loader_pkg holds the state typedef/localparams (ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_HOLD=2'd2) and the FRAME_LEN computation function.
- One sub-module is natural: shift_accum (WIDTH-bit shift register with clear, shift enable and direction parameter).
- FSM, counter and handshake stay in the top.

Test Plan:
1. WIDTH=8, MSB_FIRST=1. start, then 8 consecutive bit_valid with bits 1,0,1,0,0,1,0,1 -> out_valid=1 exactly one cycle after the 8th bit, out_data=8'hA5, busy=0 in HOLD.
2. Same bits with MSB_FIRST=0 and bit_valid gaps of 3 cycles between bits -> out_data=8'hA5 reversed = 8'hA5 (palindrome check), then repeat with 1,1,0,0,0,0,0,0 -> 8'h03.
3. Backpressure: out_ready=0 for 10 cycles after out_valid, with extra start/bit_valid pulses -> out_valid and out_data hold; out_ready=1 -> out_valid=0 next cycle.
4. Back-to-back: out_ready=1 and start=1 in the same HOLD cycle, then 8 bits of 8'h3C -> second word 8'h3C delivered, no lost or duplicate words.
5. Abort/reset: start, 4 bits, start again, then 8 bits of 8'hF0 -> out_data=8'hF0. Separately, rst_n=0 during SHIFT and again during HOLD -> all outputs 0 next cycle, state IDLE.
6. With SERIAL_WORD_LOADER_PARITY_EN: 8'hA5 plus parity 0 -> out_perr=0; 8'hA5 plus parity 1 -> out_perr=1, out_data=8'hA5. Without the macro, the 9th bit starts no frame and out_perr stays 0.
